// File: rtl/file_stream_driver.sv
// -----------------------------------------------------------------------------
// file_stream_driver
//
// Streams a word image as VECTOR_SIZE-lane beats over a valid/ready handshake.
// Adds per-frame last, programmable inter-beat gaps, pause/resume via enIn,
// a sticky done flag and an accepted-beat counter.
//
// The word source is held in the parameter FILE_IMAGE. It contains FILE_WORDS
// words, and word k sits at [k*DATA_WIDTH +: DATA_WIDTH]. A read pointer plays
// the role of the file offset: it advances by VECTOR_SIZE per fetch, and it
// returns to word 0 on reset. FILE_WORDS = 0 models an empty file.
//
// Ports
//   clkIn         in   1                       clock
//   rstIn         in   1                       asynchronous, active-high reset
//   enIn          in   1                       run enable; 0 pauses before the next fetch
//   readyIn       in   1                       sink accepts when validOut != 0 && readyIn
//   dataOut       out  DATA_WIDTH*VECTOR_SIZE  lane i at [DATA_WIDTH*i +: DATA_WIDTH]
//   validOut      out  VECTOR_SIZE             per-lane valid, nonzero only while presenting
//   lastOut       out  1                       final beat of frame or image
//   doneOut       out  1                       sticky: image exhausted, last beat accepted
//   beatCountOut  out  32                      accepted beats since reset
// -----------------------------------------------------------------------------
module file_stream_driver #(
   parameter int DATA_WIDTH  = 32,
   parameter int VECTOR_SIZE = 1,
   parameter int FILE_WORDS  = 0,
   parameter logic [((FILE_WORDS > 0) ? FILE_WORDS : 1)*DATA_WIDTH-1:0] FILE_IMAGE = '0,
   parameter int FRAME_LEN   = 0,
   parameter int GAP_CYCLES  = 0
) (
   input  logic                              clkIn,
   input  logic                              rstIn,
   input  logic                              enIn,
   input  logic                              readyIn,
   output logic [DATA_WIDTH*VECTOR_SIZE-1:0] dataOut,
   output logic [VECTOR_SIZE-1:0]            validOut,
   output logic                              lastOut,
   output logic                              doneOut,
   output logic [31:0]                       beatCountOut
);

   localparam int IMG_WORDS = (FILE_WORDS > 0) ? FILE_WORDS : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_PRESENT,
      S_GAP,
      S_DONE
   } state_t;

   state_t                            state_q, state_d;
   logic [31:0]                       ptr_q, ptr_d;
   logic [DATA_WIDTH*VECTOR_SIZE-1:0] data_q, data_d;
   logic [VECTOR_SIZE-1:0]            valid_q, valid_d;
   logic                              last_q, last_d;
   logic                              exhausted_q, exhausted_d;
   logic [31:0]                       beat_cnt_q, beat_cnt_d;
   logic [31:0]                       frame_cnt_q, frame_cnt_d;
   logic [31:0]                       gap_cnt_q, gap_cnt_d;

   // The candidate beat at the current read pointer, valid whenever a fetch is
   // requested.
   logic [DATA_WIDTH*VECTOR_SIZE-1:0] fetch_data;
   logic [VECTOR_SIZE-1:0]            fetch_valid;
   logic                              fetch_any;
   logic                              fetch_eof;
   logic                              fetch_now;

   genvar gi;
   generate
      for (gi = 0; gi < VECTOR_SIZE; gi++) begin : g_lane
         logic [31:0]           lane_idx;
         logic                  lane_valid;
         logic [DATA_WIDTH-1:0] lane_data;

         always_comb begin
            lane_idx   = ptr_q + 32'(gi);
            lane_valid = (lane_idx < 32'(FILE_WORDS));
            lane_data  = '0;
            // Word select as an explicit mux; lanes past the end stay zero.
            for (int w = 0; w < IMG_WORDS; w++) begin
               if (lane_valid && (lane_idx == 32'(w))) begin
                  lane_data = FILE_IMAGE[w*DATA_WIDTH +: DATA_WIDTH];
               end
            end
         end

         assign fetch_valid[gi]                          = lane_valid;
         assign fetch_data[gi*DATA_WIDTH +: DATA_WIDTH]  = lane_data;
      end
   endgenerate

   assign fetch_any = (ptr_q < 32'(FILE_WORDS));
   // End of image is reached once this read consumes the final word.
   assign fetch_eof = ((ptr_q + 32'(VECTOR_SIZE)) >= 32'(FILE_WORDS));

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      last_d      = last_q;
      exhausted_d = exhausted_q;
      beat_cnt_d  = beat_cnt_q;
      frame_cnt_d = frame_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      fetch_now   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (enIn) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            fetch_now = 1'b1;
         end
         S_PRESENT: begin
            if (readyIn) begin
               beat_cnt_d  = beat_cnt_q + 32'd1;
               frame_cnt_d = last_q ? 32'd0 : frame_cnt_q + 32'd1;
               data_d      = '0;
               valid_d     = '0;
               last_d      = 1'b0;
               if (exhausted_q) begin
                  state_d = S_DONE;
               end else if (GAP_CYCLES > 0) begin
                  state_d   = S_GAP;
                  gap_cnt_d = 32'(GAP_CYCLES - 1);
               end else if (enIn) begin
                  // Back-to-back: the next beat replaces this one on the accept edge.
                  fetch_now = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q == 32'd0) begin
               if (enIn) begin
                  fetch_now = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - 32'd1;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (fetch_now) begin
         if (fetch_any) begin
            state_d     = S_PRESENT;
            data_d      = fetch_data;
            valid_d     = fetch_valid;
            // Frame position uses the post-accept frame count so a fetch on
            // the accept edge sees the index of the beat being loaded.
            last_d      = fetch_eof ||
                          ((FRAME_LEN != 0) && (frame_cnt_d == 32'(FRAME_LEN - 1)));
            exhausted_d = fetch_eof;
            ptr_d       = ptr_q + 32'(VECTOR_SIZE);
         end else begin
            state_d = S_DONE;
         end
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         data_q      <= '0;
         valid_q     <= '0;
         last_q      <= 1'b0;
         exhausted_q <= 1'b0;
         beat_cnt_q  <= '0;
         frame_cnt_q <= '0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         exhausted_q <= exhausted_d;
         beat_cnt_q  <= beat_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign dataOut      = data_q;
   assign validOut     = valid_q;
   assign lastOut      = last_q;
   assign doneOut      = (state_q == S_DONE);
   assign beatCountOut = beat_cnt_q;

endmodule

// File: tb/tb_file_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_file_stream_driver
//
// Six driver instances with different configurations share one clock:
//   0: V=1, 8 words 0..7                  (back-to-back, backpressure, reset replay)
//   1: V=4, 10 words                      (partial final vector)
//   2: V=1, FRAME_LEN=3, 7 words          (frame last, random handshake)
//   3: V=1, GAP_CYCLES=2, 10 words        (gap pattern, pause)
//   4: empty image
//   5: V=3, FRAME_LEN=4, GAP=1, 17 words  (random handshake plus mid-run reset)
// A monitor compares every instance against a beat-level model. The model
// derives the contents of beat b from the image, the lane count and the frame
// length. Directed tables and sequences cover the cycle-exact corner cases.
// -----------------------------------------------------------------------------
module tb_file_stream_driver;

   localparam int DW = 16;
   localparam int NI = 6;

   logic clkIn = 1'b0;
   always #5 clkIn = ~clkIn;

   logic rst [NI];
   logic en  [NI];
   logic rdy [NI];

   int checks = 0;
   int errors = 0;

   // ---------------- configuration and beat-level model ----------------
   function automatic int cfg_v(int i);
      case (i)
         1:       return 4;
         5:       return 3;
         default: return 1;
      endcase
   endfunction

   function automatic int cfg_n(int i);
      case (i)
         0:       return 8;
         1:       return 10;
         2:       return 7;
         3:       return 10;
         4:       return 0;
         default: return 17;
      endcase
   endfunction

   function automatic int cfg_fl(int i);
      case (i)
         2:       return 3;
         5:       return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [15:0] word_val(int i, int idx);
      case (i)
         0:       return 16'(idx);
         1:       return 16'(32'h100 + idx);
         2:       return 16'(32'h10 + idx);
         3:       return 16'(32'h20 + idx);
         default: return 16'((idx * 37 + 5) & 32'hffff);
      endcase
   endfunction

   function automatic logic [511:0] make_image(int i);
      logic [511:0] img;
      img = '0;
      for (int k = 0; k < cfg_n(i); k++) img[k*16 +: 16] = word_val(i, k);
      return img;
   endfunction

   function automatic int nbeats(int i);
      return (cfg_n(i) + cfg_v(i) - 1) / cfg_v(i);
   endfunction

   function automatic logic [63:0] exp_data(int i, int b);
      logic [63:0] d;
      d = '0;
      for (int k = 0; k < cfg_v(i); k++)
         if (b * cfg_v(i) + k < cfg_n(i)) d[k*16 +: 16] = word_val(i, b * cfg_v(i) + k);
      return d;
   endfunction

   function automatic logic [3:0] exp_valid(int i, int b);
      logic [3:0] v;
      v = '0;
      for (int k = 0; k < cfg_v(i); k++)
         if (b * cfg_v(i) + k < cfg_n(i)) v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic exp_last(int i, int b);
      return (b == nbeats(i) - 1) || ((cfg_fl(i) != 0) && (b % cfg_fl(i) == cfg_fl(i) - 1));
   endfunction

   localparam logic [511:0] IMG0 = make_image(0);
   localparam logic [511:0] IMG1 = make_image(1);
   localparam logic [511:0] IMG2 = make_image(2);
   localparam logic [511:0] IMG3 = make_image(3);
   localparam logic [511:0] IMG5 = make_image(5);

   // ---------------- DUT instances ----------------
   logic [15:0] d_a, d_c, d_d, d_e;
   logic [63:0] d_b;
   logic [47:0] d_f;
   logic [0:0]  v_a, v_c, v_d, v_e;
   logic [3:0]  v_b;
   logic [2:0]  v_f;
   logic        l_a, l_b, l_c, l_d, l_e, l_f;
   logic        dn_a, dn_b, dn_c, dn_d, dn_e, dn_f;
   logic [31:0] c_a, c_b, c_c, c_d, c_e, c_f;

   file_stream_driver #(.DATA_WIDTH(DW), .VECTOR_SIZE(1), .FILE_WORDS(8),
      .FILE_IMAGE(IMG0[8*DW-1:0]), .FRAME_LEN(0), .GAP_CYCLES(0)) dut_a (
      .clkIn(clkIn), .rstIn(rst[0]), .enIn(en[0]), .readyIn(rdy[0]),
      .dataOut(d_a), .validOut(v_a), .lastOut(l_a), .doneOut(dn_a), .beatCountOut(c_a));

   file_stream_driver #(.DATA_WIDTH(DW), .VECTOR_SIZE(4), .FILE_WORDS(10),
      .FILE_IMAGE(IMG1[10*DW-1:0]), .FRAME_LEN(0), .GAP_CYCLES(0)) dut_b (
      .clkIn(clkIn), .rstIn(rst[1]), .enIn(en[1]), .readyIn(rdy[1]),
      .dataOut(d_b), .validOut(v_b), .lastOut(l_b), .doneOut(dn_b), .beatCountOut(c_b));

   file_stream_driver #(.DATA_WIDTH(DW), .VECTOR_SIZE(1), .FILE_WORDS(7),
      .FILE_IMAGE(IMG2[7*DW-1:0]), .FRAME_LEN(3), .GAP_CYCLES(0)) dut_c (
      .clkIn(clkIn), .rstIn(rst[2]), .enIn(en[2]), .readyIn(rdy[2]),
      .dataOut(d_c), .validOut(v_c), .lastOut(l_c), .doneOut(dn_c), .beatCountOut(c_c));

   file_stream_driver #(.DATA_WIDTH(DW), .VECTOR_SIZE(1), .FILE_WORDS(10),
      .FILE_IMAGE(IMG3[10*DW-1:0]), .FRAME_LEN(0), .GAP_CYCLES(2)) dut_d (
      .clkIn(clkIn), .rstIn(rst[3]), .enIn(en[3]), .readyIn(rdy[3]),
      .dataOut(d_d), .validOut(v_d), .lastOut(l_d), .doneOut(dn_d), .beatCountOut(c_d));

   file_stream_driver #(.DATA_WIDTH(DW), .VECTOR_SIZE(1), .FILE_WORDS(0),
      .FILE_IMAGE(16'h0000), .FRAME_LEN(0), .GAP_CYCLES(0)) dut_e (
      .clkIn(clkIn), .rstIn(rst[4]), .enIn(en[4]), .readyIn(rdy[4]),
      .dataOut(d_e), .validOut(v_e), .lastOut(l_e), .doneOut(dn_e), .beatCountOut(c_e));

   file_stream_driver #(.DATA_WIDTH(DW), .VECTOR_SIZE(3), .FILE_WORDS(17),
      .FILE_IMAGE(IMG5[17*DW-1:0]), .FRAME_LEN(4), .GAP_CYCLES(1)) dut_f (
      .clkIn(clkIn), .rstIn(rst[5]), .enIn(en[5]), .readyIn(rdy[5]),
      .dataOut(d_f), .validOut(v_f), .lastOut(l_f), .doneOut(dn_f), .beatCountOut(c_f));

   // Uniform views of the outputs of all instances.
   logic [63:0] mon_data  [NI];
   logic [3:0]  mon_valid [NI];
   logic        mon_last  [NI];
   logic        mon_done  [NI];
   logic [31:0] mon_cnt   [NI];

   assign mon_data[0] = 64'(d_a);  assign mon_valid[0] = 4'(v_a);
   assign mon_data[1] = d_b;       assign mon_valid[1] = v_b;
   assign mon_data[2] = 64'(d_c);  assign mon_valid[2] = 4'(v_c);
   assign mon_data[3] = 64'(d_d);  assign mon_valid[3] = 4'(v_d);
   assign mon_data[4] = 64'(d_e);  assign mon_valid[4] = 4'(v_e);
   assign mon_data[5] = 64'(d_f);  assign mon_valid[5] = 4'(v_f);
   assign mon_last[0] = l_a;  assign mon_done[0] = dn_a;  assign mon_cnt[0] = c_a;
   assign mon_last[1] = l_b;  assign mon_done[1] = dn_b;  assign mon_cnt[1] = c_b;
   assign mon_last[2] = l_c;  assign mon_done[2] = dn_c;  assign mon_cnt[2] = c_c;
   assign mon_last[3] = l_d;  assign mon_done[3] = dn_d;  assign mon_cnt[3] = c_d;
   assign mon_last[4] = l_e;  assign mon_done[4] = dn_e;  assign mon_cnt[4] = c_e;
   assign mon_last[5] = l_f;  assign mon_done[5] = dn_f;  assign mon_cnt[5] = c_f;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   int          exp_beat [NI];
   logic        hold     [NI];
   logic [63:0] h_data   [NI];
   logic [3:0]  h_valid  [NI];
   logic        h_last   [NI];

   initial begin
      for (int i = 0; i < NI; i++) begin
         exp_beat[i] = 0;
         hold[i]     = 1'b0;
      end
      forever begin
         @(negedge clkIn);
         for (int i = 0; i < NI; i++) begin
            if (rst[i]) begin
               chk($sformatf("reset_ctl%0d", i),
                   {26'b0, mon_valid[i], mon_last[i], mon_done[i], mon_cnt[i]}, 64'd0);
               chk($sformatf("reset_data%0d", i), mon_data[i], 64'd0);
               exp_beat[i] = 0;
               hold[i]     = 1'b0;
            end else begin
               chk($sformatf("count%0d", i), 64'(mon_cnt[i]), 64'(exp_beat[i]));
               if (hold[i]) begin
                  chk($sformatf("hold_data%0d", i), mon_data[i], h_data[i]);
                  chk($sformatf("hold_ctl%0d", i), {59'b0, mon_valid[i], mon_last[i]},
                      {59'b0, h_valid[i], h_last[i]});
               end
               if (mon_done[i])
                  chk($sformatf("done_state%0d", i), {27'b0, mon_valid[i], 32'(exp_beat[i])},
                      {31'b0, 32'(nbeats(i))});
               if (mon_valid[i] != 4'd0) begin
                  if (exp_beat[i] >= nbeats(i)) begin
                     checks++;
                     errors++;
                     $display("FAIL extra_beat%0d actual=valid %h required=no beat", i, mon_valid[i]);
                  end else begin
                     chk($sformatf("beat_data%0d_%0d", i, exp_beat[i]), mon_data[i],
                         exp_data(i, exp_beat[i]));
                     chk($sformatf("beat_ctl%0d_%0d", i, exp_beat[i]),
                         {59'b0, mon_valid[i], mon_last[i]},
                         {59'b0, exp_valid(i, exp_beat[i]), exp_last(i, exp_beat[i])});
                     if (rdy[i]) begin
                        $display("inst %0d beat %0d data %h valid %h last %b",
                                 i, exp_beat[i], mon_data[i], mon_valid[i], mon_last[i]);
                        exp_beat[i]++;
                     end
                  end
               end
               hold[i]    = (mon_valid[i] != 4'd0) && !rdy[i];
               h_data[i]  = mon_data[i];
               h_valid[i] = mon_valid[i];
               h_last[i]  = mon_last[i];
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic wait_valid(int i, int budget, string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clkIn);
         if (mon_valid[i] != 4'd0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s actual=no valid required=valid within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_done(int i, int budget, string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clkIn);
         if (mon_done[i]) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s actual=not done required=done within %0d cycles", name, budget);
      end
   endtask

   typedef struct {
      logic        en;
      logic        rdy;
      logic        vld;
      logic [15:0] data;
      logic        last;
      logic        done;
      logic [31:0] cnt;
   } vec_t;

   vec_t t1 [12];

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b1;
         en[i]  = 1'b0;
         rdy[i] = 1'b0;
      end

      // Expected cycle-by-cycle view of instance 0 with enIn=readyIn=1:
      // two invalid cycles (IDLE, FETCH), eight back-to-back beats, then done.
      for (int r = 0; r < 12; r++) begin
         t1[r].en  = 1'b1;
         t1[r].rdy = 1'b1;
         if (r < 2) begin
            t1[r].vld = 1'b0; t1[r].data = 16'd0; t1[r].last = 1'b0;
            t1[r].done = 1'b0; t1[r].cnt = 32'd0;
         end else if (r < 10) begin
            t1[r].vld = 1'b1; t1[r].data = 16'(r - 2); t1[r].last = (r == 9);
            t1[r].done = 1'b0; t1[r].cnt = 32'(r - 2);
         end else begin
            t1[r].vld = 1'b0; t1[r].data = 16'd0; t1[r].last = 1'b0;
            t1[r].done = 1'b1; t1[r].cnt = 32'd8;
         end
      end

      repeat (3) @(posedge clkIn);
      #1;
      for (int i = 0; i < NI; i++) rst[i] = 1'b0;

      // T1: back-to-back stream, table driven.
      for (int r = 0; r < 12; r++) begin
         @(posedge clkIn); #1;
         en[0]  = t1[r].en;
         rdy[0] = t1[r].rdy;
         @(negedge clkIn);
         chk($sformatf("t1_valid_r%0d", r), 64'(v_a), 64'(t1[r].vld));
         if (t1[r].vld) begin
            chk($sformatf("t1_data_r%0d", r), 64'(d_a), 64'(t1[r].data));
            chk($sformatf("t1_last_r%0d", r), 64'(l_a), 64'(t1[r].last));
         end
         chk($sformatf("t1_done_r%0d", r), 64'(dn_a), 64'(t1[r].done));
         chk($sformatf("t1_count_r%0d", r), 64'(c_a), 64'(t1[r].cnt));
      end

      // T2: readyIn alternating; scoreboard checks order and stability.
      @(posedge clkIn); #1; en[0] = 1'b0; rst[0] = 1'b1;
      @(posedge clkIn); #1; rst[0] = 1'b0; en[0] = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(posedge clkIn); #1;
         rdy[0] = (c % 2 == 0);
      end
      @(negedge clkIn);
      chk("t2_count", 64'(c_a), 64'd8);
      chk("t2_done", 64'(dn_a), 64'd1);

      // T6: reset after beat 3 replays from word 0.
      @(posedge clkIn); #1; rst[0] = 1'b1;
      @(posedge clkIn); #1; rst[0] = 1'b0; en[0] = 1'b1; rdy[0] = 1'b1;
      begin
         bit seen3;
         seen3 = 1'b0;
         for (int c = 0; c < 20; c++) begin
            @(negedge clkIn);
            if (c_a == 32'd3) begin
               seen3 = 1'b1;
               break;
            end
         end
         if (!seen3) begin
            checks++;
            errors++;
            $display("FAIL t6_reach3 actual=%0d required=3", c_a);
         end
      end
      @(posedge clkIn); #1; rst[0] = 1'b1;
      @(posedge clkIn); #1; rst[0] = 1'b0;
      @(negedge clkIn);
      chk("t6_count_after_reset", 64'(c_a), 64'd0);
      wait_valid(0, 10, "t6_restart");
      chk("t6_first_word", {47'b0, v_a, d_a}, {47'b0, 1'b1, 16'd0});
      wait_done(0, 30, "t6_done");
      chk("t6_final_count", 64'(c_a), 64'd8);

      // T3: four lanes, partial final vector.
      @(posedge clkIn); #1; en[1] = 1'b1; rdy[1] = 1'b1;
      wait_done(1, 30, "t3_done");
      chk("t3_count", 64'(c_b), 64'd3);

      // T4 and randomized run: random enable/ready on instances 2 and 5,
      // with one reset of instance 5 part-way through.
      for (int c = 0; c < 800; c++) begin
         @(posedge clkIn); #1;
         en[2]  = ($urandom_range(0, 3) != 0);
         rdy[2] = ($urandom_range(0, 1) != 0);
         en[5]  = ($urandom_range(0, 3) != 0);
         rdy[5] = ($urandom_range(0, 1) != 0);
         rst[5] = (c == 25);
         if (c > 30 && dn_c && dn_f) break;
      end
      rst[5] = 1'b0;
      @(negedge clkIn);
      chk("t4_done", 64'(dn_c), 64'd1);
      chk("t4_count", 64'(c_c), 64'd7);
      chk("rand_done", 64'(dn_f), 64'd1);
      chk("rand_count", 64'(c_f), 64'd6);

      // T5: gap pattern 1,0,0 then a five-cycle pause.
      @(posedge clkIn); #1; en[3] = 1'b1; rdy[3] = 1'b1;
      wait_valid(3, 10, "t5_start");
      for (int j = 0; j < 9; j++) begin
         if (j > 0) @(negedge clkIn);
         chk($sformatf("t5_gap_c%0d", j), 64'(v_d), 64'(j % 3 == 0));
      end
      @(posedge clkIn); #1; en[3] = 1'b0;
      repeat (5) @(posedge clkIn);
      #1; en[3] = 1'b1;
      wait_done(3, 60, "t5_done");
      chk("t5_count", 64'(c_d), 64'd10);

      // Empty image: done without any valid beat.
      @(posedge clkIn); #1; en[4] = 1'b1; rdy[4] = 1'b1;
      repeat (10) @(negedge clkIn);
      chk("empty_done", 64'(dn_e), 64'd1);
      chk("empty_count", 64'(c_e), 64'd0);

      @(negedge clkIn);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
